// File: rtl/bf_core.sv
// bf_core: Brainfuck execution core sitting between a synchronous program
// ROM, a synchronous data RAM and byte-wide stdin/stdout handshake streams.
// All outputs are registered; the program counter is the prog_addr output
// register and the data pointer is the data_addr output register.
module bf_core #(
    parameter int DATA_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int PROG_ADDR_WIDTH = 8,
    parameter int STACK_DEPTH     = 8,
    parameter int SP_WIDTH        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
    output logic                       prog_ren,
    input  logic [7:0]                 prog_rdata,
    output logic [DATA_ADDR_WIDTH-1:0] data_addr,
    output logic                       data_ren,
    input  logic [DATA_WIDTH-1:0]      data_rdata,
    output logic                       data_wen,
    output logic [DATA_WIDTH-1:0]      data_wdata,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       halted,
    output logic                       error,
    output logic [1:0]                 error_code
);

    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int DEPTH_W = PROG_ADDR_WIDTH + 1;

    localparam logic [7:0] CH_RIGHT = 8'h3E;
    localparam logic [7:0] CH_LEFT  = 8'h3C;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_OUT   = 8'h2E;
    localparam logic [7:0] CH_IN    = 8'h2C;
    localparam logic [7:0] CH_OPEN  = 8'h5B;
    localparam logic [7:0] CH_CLOSE = 8'h5D;
    localparam logic [7:0] CH_NUL   = 8'h00;

    localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
    localparam logic [1:0] ERR_UNMATCHED = 2'd3;

    localparam logic [PROG_ADDR_WIDTH-1:0] PC_ZERO   = {PROG_ADDR_WIDTH{1'b0}};
    localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE    = {{(PROG_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_ADDR_WIDTH-1:0] DA_ZERO   = {DATA_ADDR_WIDTH{1'b0}};
    localparam logic [DATA_ADDR_WIDTH-1:0] DA_ONE    = {{(DATA_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]      D_ZERO    = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]      D_ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SP_WIDTH-1:0]        SP_ZERO   = {SP_WIDTH{1'b0}};
    localparam logic [SP_WIDTH-1:0]        SP_ONE    = {{(SP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SP_WIDTH-1:0]        SP_FULL   = SP_WIDTH'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0]         DEPTH_ZERO = {DEPTH_W{1'b0}};
    localparam logic [DEPTH_W-1:0]         DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_FETCH       = 4'd0,
        ST_DECODE      = 4'd1,
        ST_MEM         = 4'd2,
        ST_EXEC        = 4'd3,
        ST_SKIP_FETCH  = 4'd4,
        ST_SKIP_DECODE = 4'd5,
        ST_IN_WAIT     = 4'd6,
        ST_OUT_WAIT    = 4'd7,
        ST_HALT        = 4'd8,
        ST_ERROR       = 4'd9
    } state_t;

    state_t                     state_r;
    logic [7:0]                 op_r;
    logic [SP_WIDTH-1:0]        sp_r;
    logic [DEPTH_W-1:0]         depth_r;
    logic [PROG_ADDR_WIDTH-1:0] stack_r [STACK_DEPTH];

    logic [PROG_ADDR_WIDTH-1:0] pc_inc_s;
    logic [PROG_ADDR_WIDTH-1:0] loop_target_s;
    logic [IDX_W-1:0]           push_idx_s;
    logic [IDX_W-1:0]           top_idx_s;
    logic                       cell_zero_s;

    // Next PC, stack slot indices, loop-return address and zero-cell test.
    always_comb begin
        pc_inc_s      = prog_addr + PC_ONE;
        push_idx_s    = IDX_W'(sp_r);
        top_idx_s     = IDX_W'(sp_r - SP_ONE);
        loop_target_s = stack_r[top_idx_s] + PC_ONE;
        cell_zero_s   = (data_rdata == D_ZERO);
    end

    // Sequencer: state, pointers, loop stack and every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            op_r       <= CH_NUL;
            sp_r       <= SP_ZERO;
            depth_r    <= DEPTH_ZERO;
            prog_addr  <= PC_ZERO;
            prog_ren   <= 1'b0;
            data_addr  <= DA_ZERO;
            data_ren   <= 1'b0;
            data_wen   <= 1'b0;
            data_wdata <= D_ZERO;
            in_ready   <= 1'b0;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            halted     <= 1'b0;
            error      <= 1'b0;
            error_code <= 2'd0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= PC_ZERO;
            end
        end else if (en) begin
            // Strobes are single-cycle unless re-asserted below.
            prog_ren <= 1'b0;
            data_ren <= 1'b0;
            data_wen <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    op_r <= prog_rdata;
                    case (prog_rdata)
                        CH_RIGHT: begin
                            data_addr <= data_addr + DA_ONE;
                            prog_addr <= pc_inc_s;
                            prog_ren  <= 1'b1;
                            state_r   <= ST_FETCH;
                        end
                        CH_LEFT: begin
                            data_addr <= data_addr - DA_ONE;
                            prog_addr <= pc_inc_s;
                            prog_ren  <= 1'b1;
                            state_r   <= ST_FETCH;
                        end
                        CH_PLUS, CH_MINUS, CH_OUT, CH_OPEN, CH_CLOSE: begin
                            data_ren <= 1'b1;
                            state_r  <= ST_MEM;
                        end
                        CH_IN: begin
                            in_ready <= 1'b1;
                            state_r  <= ST_IN_WAIT;
                        end
                        CH_NUL: begin
                            halted  <= 1'b1;
                            state_r <= ST_HALT;
                        end
                        default: begin
                            prog_addr <= pc_inc_s;
                            prog_ren  <= 1'b1;
                            state_r   <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (op_r)
                        CH_PLUS, CH_MINUS: begin
                            data_wdata <= (op_r == CH_PLUS) ? (data_rdata + D_ONE)
                                                            : (data_rdata - D_ONE);
                            data_wen   <= 1'b1;
                            prog_addr  <= pc_inc_s;
                            prog_ren   <= 1'b1;
                            state_r    <= ST_FETCH;
                        end
                        CH_OUT: begin
                            out_data  <= 8'(data_rdata);
                            out_valid <= 1'b1;
                            state_r   <= ST_OUT_WAIT;
                        end
                        CH_OPEN: begin
                            if (cell_zero_s) begin
                                depth_r   <= DEPTH_ONE;
                                prog_addr <= pc_inc_s;
                                prog_ren  <= 1'b1;
                                state_r   <= ST_SKIP_FETCH;
                            end else if (sp_r == SP_FULL) begin
                                error      <= 1'b1;
                                error_code <= ERR_OVERFLOW;
                                state_r    <= ST_ERROR;
                            end else begin
                                stack_r[push_idx_s] <= prog_addr;
                                sp_r      <= sp_r + SP_ONE;
                                prog_addr <= pc_inc_s;
                                prog_ren  <= 1'b1;
                                state_r   <= ST_FETCH;
                            end
                        end
                        CH_CLOSE: begin
                            if (sp_r == SP_ZERO) begin
                                error      <= 1'b1;
                                error_code <= ERR_UNDERFLOW;
                                state_r    <= ST_ERROR;
                            end else if (cell_zero_s) begin
                                sp_r      <= sp_r - SP_ONE;
                                prog_addr <= pc_inc_s;
                                prog_ren  <= 1'b1;
                                state_r   <= ST_FETCH;
                            end else begin
                                prog_addr <= loop_target_s;
                                prog_ren  <= 1'b1;
                                state_r   <= ST_FETCH;
                            end
                        end
                        default: begin
                            prog_addr <= pc_inc_s;
                            prog_ren  <= 1'b1;
                            state_r   <= ST_FETCH;
                        end
                    endcase
                end
                ST_SKIP_FETCH: begin
                    state_r <= ST_SKIP_DECODE;
                end
                ST_SKIP_DECODE: begin
                    case (prog_rdata)
                        CH_OPEN: begin
                            depth_r   <= depth_r + DEPTH_ONE;
                            prog_addr <= pc_inc_s;
                            prog_ren  <= 1'b1;
                            state_r   <= ST_SKIP_FETCH;
                        end
                        CH_CLOSE: begin
                            depth_r   <= depth_r - DEPTH_ONE;
                            prog_addr <= pc_inc_s;
                            prog_ren  <= 1'b1;
                            state_r   <= (depth_r == DEPTH_ONE) ? ST_FETCH : ST_SKIP_FETCH;
                        end
                        CH_NUL: begin
                            error      <= 1'b1;
                            error_code <= ERR_UNMATCHED;
                            state_r    <= ST_ERROR;
                        end
                        default: begin
                            prog_addr <= pc_inc_s;
                            prog_ren  <= 1'b1;
                            state_r   <= ST_SKIP_FETCH;
                        end
                    endcase
                end
                ST_IN_WAIT: begin
                    if (in_valid && in_ready) begin
                        data_wdata <= DATA_WIDTH'(in_data);
                        data_wen   <= 1'b1;
                        in_ready   <= 1'b0;
                        prog_addr  <= pc_inc_s;
                        prog_ren   <= 1'b1;
                        state_r    <= ST_FETCH;
                    end else begin
                        state_r <= ST_IN_WAIT;
                    end
                end
                ST_OUT_WAIT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        prog_addr <= pc_inc_s;
                        prog_ren  <= 1'b1;
                        state_r   <= ST_FETCH;
                    end else begin
                        state_r <= ST_OUT_WAIT;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_core.sv
// Self-checking bench for bf_core: behavioural ROM/RAM, stdin driver and an
// output scoreboard fed with expected stdout bytes per program.
module tb_bf_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [7:0] prog_addr;
    logic       prog_ren;
    logic [7:0] prog_rdata = 8'h00;
    logic [7:0] data_addr;
    logic       data_ren;
    logic [7:0] data_rdata = 8'h00;
    logic       data_wen;
    logic [7:0] data_wdata;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       halted;
    logic       error;
    logic [1:0] error_code;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rom [0:255];
    logic [7:0] ram [0:255];
    logic       ram_clear = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    int         cyc = 0;
    int         wen_cnt = 0;
    int         ov_rise = 0;
    int         first_halt = -1;
    logic       prev_ov = 1'b0;
    logic [40:0] snap;

    always #5 clk = ~clk;

    bf_core dut (
        .clk(clk), .reset(reset), .en(en),
        .prog_addr(prog_addr), .prog_ren(prog_ren), .prog_rdata(prog_rdata),
        .data_addr(data_addr), .data_ren(data_ren), .data_rdata(data_rdata),
        .data_wen(data_wen), .data_wdata(data_wdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted), .error(error), .error_code(error_code)
    );

    // Program ROM with its read port permanently enabled.
    always @(posedge clk) prog_rdata <= rom[prog_addr];

    // Data RAM: synchronous read and write, bulk clear between programs.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else begin
            if (data_wen) ram[data_addr] <= data_wdata;
            if (data_ren) data_rdata <= ram[data_addr];
        end
    end

    // Cycle index: 0 is the first cycle after reset is released.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Scoreboard and event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            wen_cnt = 0; ov_rise = 0; first_halt = -1; prev_ov = 1'b0;
        end else begin
            if (en && out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL out_byte: got %02h, no byte expected", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (out_data !== mon_exp) begin
                        miscompares++;
                        $display("FAIL out_byte: got %02h want %02h", out_data, mon_exp);
                    end
                end
            end
            if (en && data_wen) wen_cnt++;
            if (out_valid && !prev_ov) ov_rise++;
            prev_ov = out_valid;
            if (halted && first_halt < 0) first_halt = cyc;
        end
    end

    task automatic start_prog(input string p, input logic ready);
        reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = ready;
        exp_q.delete();
        for (int i = 0; i < 256; i++) rom[8'(i)] = 8'h00;
        for (int i = 0; i < p.len(); i++) rom[8'(i)] = p[i];
        ram_clear = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        ram_clear = 1'b0;
        reset = 1'b0;
    endtask

    task automatic run_wait(input string name, input int budget);
        int n;
        n = 0;
        while (!(halted || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(halted || error)) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: not halted after %0d cycles", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #2;
        snap = {prog_addr, prog_ren, data_addr, data_ren, data_wen, data_wdata,
                in_ready, out_data, out_valid, halted, error, error_code};
        vectors++; if (snap !== 41'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", snap); end
        start_prog("+.", 1'b1);
        exp_q.push_back(8'h01);
        run_wait("reset_pre", 100);
        en = 1'b0; reset = 1'b1;
        @(posedge clk); #2;
        snap = {prog_addr, prog_ren, data_addr, data_ren, data_wen, data_wdata,
                in_ready, out_data, out_valid, halted, error, error_code};
        vectors++; if (snap !== 41'd0) begin miscompares++; $display("FAIL reset_over_en: got %h want 0", snap); end
        en = 1'b1;
    endtask

    task automatic test_plus_out;
        start_prog("++.", 1'b1);
        exp_q.push_back(8'h02);
        run_wait("plus_out", 100);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL plus_out_missing: got %0d left want 0", exp_q.size()); end
        vectors++; if (ov_rise != 1) begin miscompares++; $display("FAIL plus_out_pulses: got %0d want 1", ov_rise); end
        vectors++; if (first_halt != 15) begin miscompares++; $display("FAIL plus_out_halt_cycle: got %0d want 15", first_halt); end
        vectors++; if (ram[0] !== 8'h02) begin miscompares++; $display("FAIL plus_out_cell0: got %02h want 02", ram[0]); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL plus_out_error: got %b want 0", error); end
    endtask

    task automatic test_input;
        int n;
        start_prog(",+.", 1'b1);
        exp_q.push_back(8'h42);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        vectors++; if (cyc != 2 || in_ready !== 1'b1) begin miscompares++; $display("FAIL in_ready_rise: got ready %b at cycle %0d want 1 at 2", in_ready, cyc); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL in_ready_hold: got %b want 1", in_ready); end
        end
        @(posedge clk); #2;
        in_data = 8'h41; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0; in_data = 8'h00;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL in_ready_clear: got %b want 0", in_ready); end
        vectors++; if (data_wen !== 1'b1 || data_wdata !== 8'h41) begin miscompares++; $display("FAIL in_write: got wen %b data %02h want 1 41", data_wen, data_wdata); end
        run_wait("input", 100);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL input_missing: got %0d left want 0", exp_q.size()); end
        vectors++; if (ram[0] !== 8'h42) begin miscompares++; $display("FAIL input_cell0: got %02h want 42", ram[0]); end
    endtask

    task automatic test_skip;
        // Trailing ']' exposes the stack pointer: it must still be empty.
        start_prog("[+[-]]+.]", 1'b1);
        exp_q.push_back(8'h01);
        run_wait("skip", 200);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL skip_missing: got %0d left want 0", exp_q.size()); end
        vectors++; if (error !== 1'b1 || error_code !== 2'd2) begin miscompares++; $display("FAIL skip_sp_empty: got err %b code %0d want 1 2", error, error_code); end
        vectors++; if (wen_cnt != 1) begin miscompares++; $display("FAIL skip_writes: got %0d want 1", wen_cnt); end
    endtask

    task automatic test_loop;
        start_prog("++[>+<-]>.]", 1'b1);
        exp_q.push_back(8'h02);
        run_wait("loop", 300);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL loop_missing: got %0d left want 0", exp_q.size()); end
        vectors++; if (wen_cnt != 6) begin miscompares++; $display("FAIL loop_writes: got %0d want 6", wen_cnt); end
        vectors++; if (ram[0] !== 8'h00 || ram[1] !== 8'h02) begin miscompares++; $display("FAIL loop_cells: got %02h %02h want 00 02", ram[0], ram[1]); end
        vectors++; if (error_code !== 2'd2) begin miscompares++; $display("FAIL loop_sp_empty: got %0d want 2", error_code); end
    endtask

    task automatic test_errors;
        string      progs [5];
        logic [1:0] codes [5];
        progs = '{"+[[[[[[[[[", "+[[[[[[[[", "]", "+]", "[+"};
        codes = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
        for (int t = 0; t < 5; t++) begin
            start_prog(progs[t], 1'b1);
            run_wait("errors", 300);
            repeat (4) @(negedge clk);
            vectors++; if (error_code !== codes[t] || error !== (codes[t] != 2'd0) || halted !== (codes[t] == 2'd0)) begin
                miscompares++; $display("FAIL err_case%0d: got err %b code %0d halt %b want code %0d", t, error, error_code, halted, codes[t]);
            end
            vectors++; if ({prog_ren, data_ren, data_wen, in_ready, out_valid} !== 5'b0) begin
                miscompares++; $display("FAIL err_strobes%0d: got %b want 00000", t, {prog_ren, data_ren, data_wen, in_ready, out_valid});
            end
        end
    endtask

    task automatic test_back_to_back;
        start_prog("-.+.", 1'b1);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        run_wait("wrap", 100);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_missing: got %0d left want 0", exp_q.size()); end
        vectors++; if (ov_rise != 2) begin miscompares++; $display("FAIL wrap_pulses: got %0d want 2", ov_rise); end
    endtask

    task automatic test_reset_mid;
        int n;
        start_prog("+.", 1'b0);
        n = 0;
        while (!out_valid && n < 30) begin @(negedge clk); n++; end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin miscompares++; $display("FAIL out_hold: got %b %02h want 1 01", out_valid, out_data); end
        end
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        snap = {prog_addr, prog_ren, data_addr, data_ren, data_wen, data_wdata,
                in_ready, out_data, out_valid, halted, error, error_code};
        vectors++; if (snap !== 41'd0) begin miscompares++; $display("FAIL mid_reset_outputs: got %h want 0", snap); end
        out_ready = 1'b1;
        exp_q.push_back(8'h02);
        reset = 1'b0;
        run_wait("mid_reset", 100);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL mid_reset_missing: got %0d left want 0", exp_q.size()); end
        vectors++; if (first_halt != 11) begin miscompares++; $display("FAIL mid_reset_restart: got halt cycle %0d want 11", first_halt); end
    endtask

    task automatic test_en_stall;
        start_prog("+.", 1'b1);
        exp_q.push_back(8'h01);
        repeat (5) @(posedge clk);
        #2; en = 1'b0;
        repeat (3) @(posedge clk);
        #2; en = 1'b1;
        run_wait("en_stall", 100);
        vectors++; if (first_halt != 14) begin miscompares++; $display("FAIL en_stall_cycle: got %0d want 14", first_halt); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL en_stall_missing: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[8'(i)] = 8'h00;
        test_reset();
        test_plus_out();
        test_input();
        test_skip();
        test_loop();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_en_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
